axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI responder (slave) terminating the CPU-side AXI master: ID-tagged AR/R/AW/W/B channels, 8-bit burst length.
- Backs the bus with a single-port synchronous SRAM that has 1-cycle read latency.
- Used as the memory model and SoC-side endpoint for the core's cache/AXI bridge.
- One outstanding read burst and one outstanding write burst at a time; the read and write engines run concurrently and share the SRAM port.

Parameters:
- ADDR_WIDTH, 16: SRAM word-address bits (capacity 4·2^ADDR_WIDTH bytes).
- ID_WIDTH, 4: width of arid/rid/awid/wid/bid.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arid  in  ID_WIDTH  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1
arsize  in  3  ignored; always 4 bytes
arburst  in  2  00 FIXED, 01 INCR, others unsupported
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  returned ID
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  last beat
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  ID_WIDTH  write ID
awaddr  in  32  write byte address
awlen  in  8  beats-1
awsize  in  3  ignored
awburst  in  2  as arburst
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  ID_WIDTH  ignored
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  response ID
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
ram_en  out  1  SRAM access enable
ram_we  out  4  SRAM byte write enables
ram_addr  out  ADDR_WIDTH  SRAM word address
ram_wdata  out  32  SRAM write data
ram_rdata  in  32  SRAM read data, valid the cycle after ram_en with ram_we=0

Behaviour:
- Reset, aresetn low, asynchronous:
  - Both FSMs go to IDLE.
  - rvalid, bvalid, rlast = 0; rdata, rid, rresp, bid, bresp = 0.
  - arready, awready, wready, ram_en, ram_we = 0.
  - arready/awready are combinational from state and gated by aresetn, so they rise in the first cycle after release.
- Reset mid-burst aborts the burst; no B or R is issued for it.
- Address mapping: word index = addr[ADDR_WIDTH+1:2]. Upper bits alias. addr[1:0] ignored.
- Burst address update per beat:
  - INCR: +1 word, wrapping modulo 2^ADDR_WIDTH.
  - FIXED: unchanged.
- Unsupported burst (10/11):
  - Read: all beats are still returned with rdata=0, rresp=10, and no SRAM access.
  - Write: all W beats are accepted with no SRAM write, then bresp=10.
- Read FSM (R_IDLE, R_REQ, R_DATA):
  - R_IDLE: arready=1. On arvalid, latch id, addr, len, burst, zero the beat counter, go to R_REQ.
  - R_REQ: ram_en=1, ram_we=0, ram_addr=current address, then go to R_DATA. Next cycle rdata<=ram_rdata, rvalid=1, rlast=(beat==len).
  - R_DATA: hold rdata/rid/rresp/rlast stable while rvalid && !rready. On rready: if rlast go to R_IDLE (arready high next cycle), else advance address and beat, go to R_REQ.
  - Best case is 2 cycles per beat; first-beat latency is 2 cycles after the AR handshake.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1. On awvalid, latch id, addr, len, burst, clear beat counter and error flag, go to W_DATA.
  - W_DATA: wready = !(read FSM in R_REQ); read has SRAM priority. On wvalid&&wready, in the same cycle drive ram_en=1, ram_we=wstrb, ram_addr, ram_wdata=wdata.
  - wlast mismatch: wlast!=(beat==len) sets the error flag, but the write is still performed.
  - At beat==len handshake go to W_RESP; excess wlast-less beats are never accepted.
  - W_RESP: bvalid=1, bid=latched id, bresp = error ? 10 : 00. Hold until bready, then go to W_IDLE.
- SRAM port mux: R_REQ drives the port; otherwise the write handshake drives it; otherwise ram_en=0.
- Read-after-write to the same word is ordered by SRAM cycle order only; no forwarding.

Test Plan:
- Single read: preload word 0x10=0xDEADBEEF; AR id=3 addr=0x40 len=0 INCR, rready=1 -> rvalid 2 cycles after AR handshake, rdata=0xDEADBEEF, rid=3, rlast=1, rresp=00.
- INCR write then read: AW addr=0x100 len=3, wdata 1..4, wstrb=F -> bvalid, bresp=00; read len=3 -> 1,2,3,4 with rlast only on beat 4.
- Backpressure and strobes: write 0x11223344 then wstrb=0101 wdata=0xAABBCCDD -> word reads 0x11BB33DD; hold rready=0 3 cycles -> rdata/rlast stable and rvalid held.
- Conflict: read in R_REQ while W beat pending -> wready=0 that cycle, write lands next cycle, both bursts complete correctly.
- Errors: arburst=10 len=1 -> 2 beats rresp=10 rdata=0 and ram_en never high; write len=1 with wlast on beat 0 -> bresp=10.
- Reset: assert aresetn mid read burst -> rvalid=0 immediately; after release arready=1 and a new burst completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI responder backed by a single-port synchronous SRAM (1-cycle read latency).
// Independent read and write engines (one burst each) share the SRAM port,
// with the read request cycle taking priority over a pending write beat.
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [31:0]           araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [31:0]           awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   wid,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    r_state_t              r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_beat;
    logic [1:0]            r_burst;
    logic                  r_first;
    logic [31:0]           r_hold;
    logic                  r_bad;
    logic [31:0]           r_beat_data;

    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_beat;
    logic [1:0]            w_burst;
    logic                  w_err;
    logic                  w_bad;
    logic                  w_fire;
    logic                  w_last_beat;
    logic                  w_beat_err;

    logic unused_inputs;
    assign unused_inputs = ^{arsize, awsize, wid,
                             araddr[31:ADDR_WIDTH+2], araddr[1:0],
                             awaddr[31:ADDR_WIDTH+2], awaddr[1:0]};

    // FIXED and INCR are the only bursts that touch the SRAM
    assign r_bad = (r_burst != BURST_FIXED) && (r_burst != BURST_INCR);
    assign w_bad = (w_burst != BURST_FIXED) && (w_burst != BURST_INCR);

    // Data for the beat just fetched: live SRAM output on the first R_DATA
    // cycle, zero for an unsupported burst.
    assign r_beat_data = r_bad ? 32'd0 : ram_rdata;

    assign rvalid = (r_state == R_DATA);
    assign rlast  = rvalid && (r_beat == r_len);
    assign rresp  = (rvalid && r_bad) ? RESP_SLVERR : RESP_OKAY;
    assign rid    = r_id;
    assign rdata  = r_first ? r_beat_data : r_hold;

    assign wready      = (w_state == W_DATA) && (r_state != R_REQ);
    assign w_fire      = wready && wvalid;
    assign w_last_beat = (w_beat == w_len);
    assign w_beat_err  = (wlast != w_last_beat) || w_bad;

    assign bvalid = (w_state == W_RESP);
    assign bresp  = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign bid    = w_id;

    // Read state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read next-state and AR handshake; arready only while out of reset
    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = aresetn;
                if (arvalid) r_next = R_REQ;
            end
            R_REQ:  r_next = R_DATA;
            R_DATA: begin
                if (rready) r_next = rlast ? R_IDLE : R_REQ;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read burst context: latch AR, step beat/address, capture fetched data for holding
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            r_first <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_first <= (r_state == R_REQ);
            if (r_first) r_hold <= r_beat_data;
            if (r_state == R_IDLE && arvalid) begin
                r_id    <= arid;
                r_addr  <= araddr[ADDR_WIDTH+1:2];
                r_len   <= arlen;
                r_burst <= arburst;
                r_beat  <= '0;
            end else if (r_state == R_DATA && rready && !rlast) begin
                r_beat <= r_beat + 8'd1;
                if (r_burst == BURST_INCR) r_addr <= r_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Write state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write next-state and AW handshake; leaves W_DATA only on the final counted beat
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = aresetn;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                if (w_fire && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst context: latch AW, step beat/address, accumulate wlast/burst errors
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else if (w_state == W_IDLE && awvalid) begin
            w_id    <= awid;
            w_addr  <= awaddr[ADDR_WIDTH+1:2];
            w_len   <= awlen;
            w_burst <= awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (w_fire) begin
            w_err <= w_err | w_beat_err;
            if (!w_last_beat) begin
                w_beat <= w_beat + 8'd1;
                if (w_burst == BURST_INCR) w_addr <= w_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // SRAM port mux: read request cycle first, else the accepted write beat
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        if (r_state == R_REQ) begin
            if (!r_bad) begin
                ram_en   = 1'b1;
                ram_addr = r_addr;
            end
        end else if (w_fire && !w_bad) begin
            ram_en    = 1'b1;
            ram_we    = wstrb;
            ram_addr  = w_addr;
            ram_wdata = wdata;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;

    localparam int AW = 16;
    localparam int IW = 4;

    logic          aclk;
    logic          aresetn;
    logic [IW-1:0] arid, rid, awid, wid, bid;
    logic [31:0]   araddr, awaddr, rdata, wdata, ram_wdata, ram_rdata;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize;
    logic [1:0]    arburst, awburst, rresp, bresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]    wstrb, ram_we;
    logic          ram_en;
    logic [AW-1:0] ram_addr;

    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;
    logic [31:0]   mem [0:(1<<AW)-1];
    int            en_total;

    int errors;
    int checks;

    typedef struct packed {
        bit              write;
        bit              early_last;
        logic [3:0]      id;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [1:0]      burst;
        logic [3:0][31:0] data;
        logic [3:0]      strb;
        logic [1:0]      exp_resp;
        logic [3:0][31:0] exp;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    axi_sram_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // SRAM model: registered read data, byte-masked writes, bench preload port
    always @(posedge aclk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Running count of SRAM-enabled cycles
    always @(posedge aclk) begin
        if (ram_en) en_total <= en_total + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic waitArready(input string name);
        int n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        checkOutput({name, "_arready"}, {31'd0, arready}, 32'd1);
    endtask

    task automatic waitAwready(input string name);
        int n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        checkOutput({name, "_awready"}, {31'd0, awready}, 32'd1);
    endtask

    task automatic waitWready(input string name);
        int n = 0;
        while (!wready && n < 50) begin tick(); n++; end
        checkOutput({name, "_wready"}, {31'd0, wready}, 32'd1);
    endtask

    task automatic waitRvalid(input string name);
        int n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        checkOutput({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    endtask

    task automatic waitBvalid(input string name);
        int n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        checkOutput({name, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    endtask

    function automatic vec_t mk(bit w, bit el, logic [3:0] id, logic [31:0] addr,
                                logic [7:0] len, logic [1:0] burst,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3,
                                logic [3:0] strb, logic [1:0] resp,
                                logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3);
        vec_t v;
        v.write      = w;
        v.early_last = el;
        v.id         = id;
        v.addr       = addr;
        v.len        = len;
        v.burst      = burst;
        v.data       = {d3, d2, d1, d0};
        v.strb       = strb;
        v.exp_resp   = resp;
        v.exp        = {e3, e2, e1, e0};
        return v;
    endfunction

    // One complete write or read burst, checking B or every R beat
    task automatic applyStimulus(input string name, input vec_t v);
        int en_start;
        if (v.write) begin
            awid = v.id; awaddr = v.addr; awlen = v.len; awburst = v.burst; awvalid = 1'b1;
            waitAwready(name);
            tick();
            awvalid = 1'b0;
            for (int b = 0; b <= int'(v.len); b++) begin
                wdata  = v.data[b];
                wstrb  = v.strb;
                wlast  = v.early_last ? (b == 0) : (b == int'(v.len));
                wvalid = 1'b1;
                waitWready(name);
                tick();
            end
            wvalid = 1'b0; wlast = 1'b0;
            waitBvalid(name);
            checkOutput({name, "_bid"},   {28'd0, bid},   {28'd0, v.id});
            checkOutput({name, "_bresp"}, {30'd0, bresp}, {30'd0, v.exp_resp});
            bready = 1'b1;
            tick();
            bready = 1'b0;
            checkOutput({name, "_bvalid_drop"}, {31'd0, bvalid}, 32'd0);
        end else begin
            en_start = en_total;
            arid = v.id; araddr = v.addr; arlen = v.len; arburst = v.burst; arvalid = 1'b1;
            rready = 1'b1;
            waitArready(name);
            tick();
            arvalid = 1'b0;
            for (int b = 0; b <= int'(v.len); b++) begin
                waitRvalid(name);
                checkOutput($sformatf("%s_b%0d_rdata", name, b), rdata, v.exp[b]);
                checkOutput($sformatf("%s_b%0d_rid", name, b), {28'd0, rid}, {28'd0, v.id});
                checkOutput($sformatf("%s_b%0d_rresp", name, b), {30'd0, rresp}, {30'd0, v.exp_resp});
                checkOutput($sformatf("%s_b%0d_rlast", name, b), {31'd0, rlast},
                            (b == int'(v.len)) ? 32'd1 : 32'd0);
                tick();
            end
            checkOutput({name, "_ram_en_cycles"}, en_total - en_start,
                        v.burst[1] ? 32'd0 : (32'(v.len) + 32'd1));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        errors = 0; checks = 0; en_total = 0;
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        vecs[0]  = mk(1, 0, 4'd1,  32'h0000_0100, 8'd3, 2'b01, 32'd1, 32'd2, 32'd3, 32'd4, 4'hF, 2'b00, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 4'd2,  32'h0000_0100, 8'd3, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00, 32'd1, 32'd2, 32'd3, 32'd4);
        vecs[2]  = mk(1, 0, 4'd5,  32'h0000_0200, 8'd0, 2'b01, 32'h1122_3344, 0, 0, 0, 4'hF, 2'b00, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 4'd6,  32'h0000_0200, 8'd0, 2'b01, 32'hAABB_CCDD, 0, 0, 0, 4'h5, 2'b00, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 4'd7,  32'h0000_0200, 8'd0, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00, 32'h11BB_33DD, 0, 0, 0);
        vecs[5]  = mk(1, 0, 4'd10, 32'h0000_0300, 8'd2, 2'b00, 32'hA, 32'hB, 32'hC, 0, 4'hF, 2'b00, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 4'd11, 32'h0000_0300, 8'd1, 2'b00, 0, 0, 0, 0, 4'h0, 2'b00, 32'hC, 32'hC, 0, 0);
        vecs[7]  = mk(1, 0, 4'd12, 32'h0003_FFFC, 8'd1, 2'b01, 32'h55, 32'h66, 0, 0, 4'hF, 2'b00, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 4'd13, 32'hABC3_FFFC, 8'd1, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00, 32'h55, 32'h66, 0, 0);
        vecs[9]  = mk(0, 0, 4'd14, 32'h0000_0000, 8'd0, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00, 32'h66, 0, 0, 0);
        vecs[10] = mk(1, 0, 4'd15, 32'h0000_0200, 8'd1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'hF, 2'b10, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 4'd0,  32'h0000_0200, 8'd0, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00, 32'h11BB_33DD, 0, 0, 0);
        vecs[12] = mk(0, 0, 4'd1,  32'h0000_0100, 8'd1, 2'b10, 0, 0, 0, 0, 4'h0, 2'b10, 32'd0, 32'd0, 0, 0);
        vecs[13] = mk(1, 1, 4'd2,  32'h0000_0500, 8'd1, 2'b01, 32'h9, 32'hA, 0, 0, 4'hF, 2'b10, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 4'd3,  32'h0000_0500, 8'd1, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00, 32'h9, 32'hA, 0, 0);

        // Reset state
        tick(); tick();
        checkOutput("rst_readies", {29'd0, arready, awready, wready}, 32'd0);
        checkOutput("rst_valids",  {29'd0, rvalid, bvalid, rlast}, 32'd0);
        checkOutput("rst_rdata",   rdata, 32'd0);
        checkOutput("rst_ids",     {24'd0, rid, bid}, 32'd0);
        checkOutput("rst_resps",   {28'd0, rresp, bresp}, 32'd0);
        checkOutput("rst_ram",     {27'd0, ram_en, ram_we}, 32'd0);
        aresetn = 1'b1;
        #1;
        checkOutput("rel_arready", {31'd0, arready}, 32'd1);
        checkOutput("rel_awready", {31'd0, awready}, 32'd1);

        // Preload word 0x10
        tick();
        pre_en = 1'b1; pre_addr = 16'h0010; pre_data = 32'hDEAD_BEEF;
        tick();
        pre_en = 1'b0;

        // Single read latency: handshake cycle, R_REQ cycle, then the beat
        arid = 4'd3; araddr = 32'h40; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
        waitArready("lat");
        tick();
        arvalid = 1'b0;
        checkOutput("lat_req_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("lat_req_ram_en", {31'd0, ram_en}, 32'd1);
        checkOutput("lat_req_addr",   {16'd0, ram_addr}, 32'h10);
        tick();
        checkOutput("lat_rvalid", {31'd0, rvalid}, 32'd1);
        checkOutput("lat_rdata",  rdata, 32'hDEAD_BEEF);
        checkOutput("lat_rid",    {28'd0, rid}, 32'd3);
        checkOutput("lat_rlast",  {31'd0, rlast}, 32'd1);
        checkOutput("lat_rresp",  {30'd0, rresp}, 32'd0);
        tick();
        checkOutput("lat_done", {30'd0, rvalid, arready}, 32'b01);

        // Table of bursts
        for (int i = 0; i < NVEC; i++) applyStimulus($sformatf("v%0d", i), vecs[i]);

        // Backpressure: rready low for 3 cycles keeps the beat stable
        arid = 4'd4; araddr = 32'h200; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
        waitArready("bp");
        tick();
        arvalid = 1'b0;
        waitRvalid("bp");
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp%0d_rvalid", i), {31'd0, rvalid}, 32'd1);
            checkOutput($sformatf("bp%0d_rdata", i),  rdata, 32'h11BB_33DD);
            checkOutput($sformatf("bp%0d_rlast", i),  {31'd0, rlast}, 32'd1);
            tick();
        end
        rready = 1'b1;
        tick();
        checkOutput("bp_rvalid_drop", {31'd0, rvalid}, 32'd0);

        // Conflict: write beat waits out the read request cycle
        awid = 4'd8; awaddr = 32'h400; awlen = 8'd1; awburst = 2'b01; awvalid = 1'b1;
        waitAwready("cf");
        tick();
        awvalid = 1'b0;
        arid = 4'd9; araddr = 32'h40; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
        waitArready("cf");
        tick();
        arvalid = 1'b0;
        wdata = 32'h77; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        #1;
        checkOutput("cf_wready_blocked", {31'd0, wready}, 32'd0);
        checkOutput("cf_ram_we_read",    {28'd0, ram_we}, 32'd0);
        tick();
        checkOutput("cf_wready",    {31'd0, wready}, 32'd1);
        checkOutput("cf_ram_we",    {28'd0, ram_we}, 32'hF);
        checkOutput("cf_ram_addr",  {16'd0, ram_addr}, 32'h100);
        checkOutput("cf_ram_wdata", ram_wdata, 32'h77);
        checkOutput("cf_rvalid",    {31'd0, rvalid}, 32'd1);
        checkOutput("cf_rdata",     rdata, 32'hDEAD_BEEF);
        tick();
        wdata = 32'h88; wlast = 1'b1;
        waitWready("cf2");
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        waitBvalid("cf");
        checkOutput("cf_bresp", {30'd0, bresp}, 32'd0);
        checkOutput("cf_bid",   {28'd0, bid}, 32'd8);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        applyStimulus("cf_rd", mk(0, 0, 4'd9, 32'h400, 8'd1, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00,
                                  32'h77, 32'h88, 0, 0));

        // Reset in the middle of a read burst
        arid = 4'd2; araddr = 32'h100; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
        waitArready("mr");
        tick();
        arvalid = 1'b0;
        waitRvalid("mr");
        #2 aresetn = 1'b0;
        #1;
        checkOutput("mr_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("mr_rlast",  {31'd0, rlast}, 32'd0);
        checkOutput("mr_arready", {31'd0, arready}, 32'd0);
        @(posedge aclk);
        #3 aresetn = 1'b1;
        #1;
        checkOutput("mr_rel_arready", {31'd0, arready}, 32'd1);
        applyStimulus("mr_rd", mk(0, 0, 4'd6, 32'h100, 8'd3, 2'b01, 0, 0, 0, 0, 4'h0, 2'b00,
                                  32'd1, 32'd2, 32'd3, 32'd4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
